step_ctrl: RTL and testbench



---
 rtl/step_pkg.sv | 18 +
 rtl/rate_ticker.sv | 31 +++
 rtl/step_ctrl.sv | 175 +++++++++++++++++
 tb/tb_step_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// Shared types for the step_ctrl execution controller: request modes and FSM states.
package step_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_STEP  = 2'b01,
    MODE_BURST = 2'b10,
    MODE_BP    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_BURST  = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

endpackage

// File: rtl/rate_ticker.sv
// Rate divider for step_ctrl: down-counter that ticks at zero, reloads from rate_div
// whenever an enable fires, and sits at zero while the controller is inactive.
module rate_ticker #(
  parameter int DIV_W = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             active,
  input  logic             load,
  input  logic [DIV_W-1:0] rate_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= rate_div;
    end else if (!active) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick = active && (cnt == '0);

endmodule

// File: rtl/step_ctrl.sv
// Execution controller producing the single registered datapath enable cpu_en.
// Breakpoint mode and PC compare are built only when STEP_BREAKPOINT_EN is defined.
module step_ctrl
  import step_pkg::*;
#(
  parameter int PC_W  = 33,
  parameter int CNT_W = 16,
  parameter int DIV_W = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             step_pulse,
  input  logic             halt_req,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [DIV_W-1:0] rate_div,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             cpu_en,
  output logic             running,
  output logic             bp_hit,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cyc_count
);

  state_e           st_q;
  mode_e            req_mode;
  logic [CNT_W-1:0] remaining;
  logic             active;
  logic             tick;
  logic             fire;
  logic             start_ok;
  logic             bp_stop;

  assign req_mode = mode_e'(mode);
  assign active   = (st_q == ST_RUN) || (st_q == ST_BURST);
  assign start_ok = step_pulse && !((req_mode == MODE_BURST) && (burst_len == '0));
  assign state    = st_q;

`ifdef STEP_BREAKPOINT_EN
  logic cmp_q;
  logic skip_q;
  logic bp_hit_q;

  // The compare sees the PC of the enable about to fire only when rate_div >= 1;
  // back-to-back enables would already be one instruction ahead.
  assign bp_stop = cmp_q && !skip_q && (pc == bp_addr);
  assign bp_hit  = bp_hit_q;
`else
  logic unused_bp;

  assign unused_bp = ^{pc, bp_addr};
  assign bp_stop   = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  rate_ticker #(.DIV_W(DIV_W)) u_ticker (
    .clock    (clock),
    .reset    (reset),
    .active   (active),
    .load     (fire),
    .rate_div (rate_div),
    .tick     (tick)
  );

  // Decide whether the next cycle carries an enable.
  always_comb begin
    // NOTE: default assignment first keeps this combinational block latch-free.
    fire = 1'b0;
    if (!halt_req) begin
      case (st_q)
        ST_IDLE:   fire = start_ok;
        ST_RUN:    fire = !step_pulse && tick && !bp_stop;
        ST_BURST:  fire = (remaining != '0) && tick;
`ifdef STEP_BREAKPOINT_EN
        ST_HALTED: fire = step_pulse;
`else
        ST_HALTED: fire = 1'b0;
`endif
        default:   fire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      st_q      <= ST_IDLE;
      remaining <= '0;
      cpu_en    <= 1'b0;
      running   <= 1'b0;
      cyc_count <= '0;
`ifdef STEP_BREAKPOINT_EN
      cmp_q     <= 1'b0;
      skip_q    <= 1'b0;
      bp_hit_q  <= 1'b0;
`endif
    end else begin
      cpu_en    <= fire;
      cyc_count <= cyc_count + CNT_W'(cpu_en);
`ifdef STEP_BREAKPOINT_EN
      skip_q    <= 1'b0;
`endif
      if (halt_req) begin
        st_q    <= ST_IDLE;
        running <= 1'b0;
      end else begin
        case (st_q)
          ST_IDLE: begin
            if (start_ok) begin
              running <= 1'b1;
              case (req_mode)
                MODE_STEP: begin
                  st_q      <= ST_BURST;
                  remaining <= '0;
                end
                MODE_BURST: begin
                  st_q      <= ST_BURST;
                  remaining <= burst_len - CNT_W'(1);
                end
                default: begin
                  st_q  <= ST_RUN;
`ifdef STEP_BREAKPOINT_EN
                  cmp_q <= (req_mode == MODE_BP);
`endif
                end
              endcase
            end
          end

          ST_RUN: begin
            if (step_pulse) begin
              st_q    <= ST_IDLE;
              running <= 1'b0;
            end else if (tick && bp_stop) begin
              st_q    <= ST_HALTED;
              running <= 1'b0;
`ifdef STEP_BREAKPOINT_EN
              bp_hit_q <= 1'b1;
`endif
            end
          end

          // remaining counts enables still owed after the one currently in flight.
          ST_BURST: begin
            if (remaining == '0) begin
              st_q    <= ST_IDLE;
              running <= 1'b0;
            end else if (tick) begin
              remaining <= remaining - CNT_W'(1);
            end
          end

          ST_HALTED: begin
`ifdef STEP_BREAKPOINT_EN
            if (step_pulse) begin
              st_q     <= ST_RUN;
              running  <= 1'b1;
              bp_hit_q <= 1'b0;
              skip_q   <= 1'b1;
            end
`else
            st_q <= ST_IDLE;
`endif
          end

          default: begin
            st_q    <= ST_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl: expected enable cycles are queued as stimulus is
// issued and consumed by a negedge monitor; also covers the STEP_BREAKPOINT_EN build.
module tb_step_ctrl;
  import step_pkg::*;

  typedef struct {
    int          cyc;
    bit          chk_pc;
    logic [32:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        step_pulse = 1'b0;
  logic        halt_req = 1'b0;
  logic [15:0] burst_len = '0;
  logic [25:0] rate_div = '0;
  logic [32:0] pc;
  logic [32:0] bp_addr = '0;
  logic        cpu_en;
  logic        running;
  logic        bp_hit;
  logic [1:0]  state;
  logic [15:0] cyc_count;

  logic        pc_clr = 1'b1;
  bit          mon_on = 1'b1;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          t;
  exp_t        exp_q[$];

  step_ctrl dut (
    .clock      (clk),
    .reset      (reset),
    .mode       (mode),
    .step_pulse (step_pulse),
    .halt_req   (halt_req),
    .burst_len  (burst_len),
    .rate_div   (rate_div),
    .pc         (pc),
    .bp_addr    (bp_addr),
    .cpu_en     (cpu_en),
    .running    (running),
    .bp_hit     (bp_hit),
    .state      (state),
    .cyc_count  (cyc_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-in: PC advances by 4 on every enabled cycle.
  always @(posedge clk) begin
    if (pc_clr) pc <= '0;
    else if (cpu_en) pc <= pc + 33'd4;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c);
    exp_t e;
    e.cyc = c;
    e.chk_pc = 1'b0;
    e.pc = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_pc(input int c, input logic [32:0] p);
    exp_t e;
    e.cyc = c;
    e.chk_pc = 1'b1;
    e.pc = p;
    exp_q.push_back(e);
  endtask

  // Advance to the negedge of cycle c (c must be later than the current cycle).
  task automatic at(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic pulse(input logic [1:0] m);
    mode = m;
    step_pulse = 1'b1;
    at(cyc + 1);
    step_pulse = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_on && cpu_en === 1'b1) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
      end else begin
        e.cyc = -1;
        e.chk_pc = 1'b0;
        e.pc = '0;
      end
      check("en_cycle", 64'(cyc), 64'(e.cyc));
      if (e.chk_pc) check("en_pc", 64'(pc), 64'(e.pc));
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    // Reset values
    at(3);
    check("rst_cpu_en", 64'(cpu_en), 64'(0));
    check("rst_running", 64'(running), 64'(0));
    check("rst_bp_hit", 64'(bp_hit), 64'(0));
    check("rst_state", 64'(state), 64'(ST_IDLE));
    check("rst_cyc_count", 64'(cyc_count), 64'(0));
    reset = 1'b1;
    pc_clr = 1'b0;
    at(10);

    // Single step, rate_div=5
    rate_div = 26'd5;
    t = cyc;
    push(t + 1);
    pulse(MODE_STEP);
    check("step_en", 64'(cpu_en), 64'(1));
    check("step_state_burst", 64'(state), 64'(ST_BURST));
    at(t + 2);
    check("step_state_idle", 64'(state), 64'(ST_IDLE));
    check("step_cyc_count", 64'(cyc_count), 64'(1));
    check("step_running", 64'(running), 64'(0));
    at(t + 9);
    check("step_q_empty", 64'(exp_q.size()), 64'(0));

    // Burst of 4, rate_div=2
    rate_div = 26'd2;
    burst_len = 16'd4;
    t = cyc;
    push(t + 1); push(t + 4); push(t + 7); push(t + 10);
    pulse(MODE_BURST);
    at(t + 10);
    check("burst_running_last", 64'(running), 64'(1));
    at(t + 11);
    check("burst_running_end", 64'(running), 64'(0));
    check("burst_state", 64'(state), 64'(ST_IDLE));
    check("burst_cyc_count", 64'(cyc_count), 64'(5));
    at(t + 16);
    check("burst_q_empty", 64'(exp_q.size()), 64'(0));

    // Burst of 0: nothing happens
    burst_len = 16'd0;
    t = cyc;
    pulse(MODE_BURST);
    check("burst0_state", 64'(state), 64'(ST_IDLE));
    check("burst0_running", 64'(running), 64'(0));
    at(t + 5);
    check("burst0_cyc_count", 64'(cyc_count), 64'(5));

    // Free run, rate_div=0, stopped by step_pulse
    rate_div = 26'd0;
    t = cyc;
    for (int i = 1; i <= 5; i++) push(t + i);
    pulse(MODE_RUN);
    check("run_running", 64'(running), 64'(1));
    at(t + 5);
    step_pulse = 1'b1;
    at(t + 6);
    step_pulse = 1'b0;
    check("run_stop_en", 64'(cpu_en), 64'(0));
    check("run_stop_state", 64'(state), 64'(ST_IDLE));
    at(t + 9);
    check("run_cyc_count", 64'(cyc_count), 64'(10));
    check("run_q_empty", 64'(exp_q.size()), 64'(0));

    // Free run stopped by halt_req
    t = cyc;
    for (int i = 1; i <= 3; i++) push(t + i);
    pulse(MODE_RUN);
    at(t + 3);
    halt_req = 1'b1;
    at(t + 4);
    halt_req = 1'b0;
    check("halt_en", 64'(cpu_en), 64'(0));
    check("halt_state", 64'(state), 64'(ST_IDLE));
    check("halt_running", 64'(running), 64'(0));
    at(t + 7);
    check("halt_cyc_count", 64'(cyc_count), 64'(13));

    // step_pulse and halt_req together: halt wins
    t = cyc;
    halt_req = 1'b1;
    pulse(MODE_RUN);
    halt_req = 1'b0;
    check("both_state", 64'(state), 64'(ST_IDLE));
    check("both_running", 64'(running), 64'(0));
    at(t + 4);
    check("both_q_empty", 64'(exp_q.size()), 64'(0));

    // Mode 11
    rate_div = 26'd1;
    bp_addr = 33'h10;
    pc_clr = 1'b1;
    at(cyc + 1);
    pc_clr = 1'b0;
    t = cyc;
`ifdef STEP_BREAKPOINT_EN
    push_pc(t + 1, 33'h0); push_pc(t + 3, 33'h4);
    push_pc(t + 5, 33'h8); push_pc(t + 7, 33'hC);
    pulse(MODE_BP);
    at(t + 8);
    check("bp_state_run", 64'(state), 64'(ST_RUN));
    check("bp_hit_before", 64'(bp_hit), 64'(0));
    at(t + 9);
    check("bp_state_halted", 64'(state), 64'(ST_HALTED));
    check("bp_hit_set", 64'(bp_hit), 64'(1));
    check("bp_en_suppressed", 64'(cpu_en), 64'(0));
    check("bp_running", 64'(running), 64'(0));
    at(t + 12);
    check("bp_hit_sticky", 64'(bp_hit), 64'(1));
    push_pc(t + 13, 33'h10);
    pulse(MODE_BP);
    check("bp_hit_cleared", 64'(bp_hit), 64'(0));
    check("bp_resume_state", 64'(state), 64'(ST_RUN));
    halt_req = 1'b1;
    at(t + 14);
    halt_req = 1'b0;
    check("bp_halt_state", 64'(state), 64'(ST_IDLE));
`else
    for (int i = 0; i < 5; i++) push(t + 1 + 2 * i);
    pulse(MODE_BP);
    at(t + 9);
    check("bp_off_state", 64'(state), 64'(ST_RUN));
    check("bp_off_hit", 64'(bp_hit), 64'(0));
    at(t + 10);
    step_pulse = 1'b1;
    at(t + 11);
    step_pulse = 1'b0;
    check("bp_off_stop_state", 64'(state), 64'(ST_IDLE));
    check("bp_off_stop_en", 64'(cpu_en), 64'(0));
`endif
    at(cyc + 3);
    check("bp_cyc_count", 64'(cyc_count), 64'(18));
    check("bp_q_empty", 64'(exp_q.size()), 64'(0));

    // Reset during a burst with 3 enables still owed
    rate_div = 26'd0;
    burst_len = 16'd5;
    t = cyc;
    push(t + 1); push(t + 2);
    pulse(MODE_BURST);
    at(t + 2);
    reset = 1'b0;
    at(t + 3);
    check("mid_rst_cpu_en", 64'(cpu_en), 64'(0));
    check("mid_rst_running", 64'(running), 64'(0));
    check("mid_rst_bp_hit", 64'(bp_hit), 64'(0));
    check("mid_rst_state", 64'(state), 64'(ST_IDLE));
    check("mid_rst_cyc_count", 64'(cyc_count), 64'(0));
    at(t + 5);
    check("mid_rst_hold_en", 64'(cpu_en), 64'(0));
    reset = 1'b1;
    at(t + 7);
    check("mid_rst_q_empty", 64'(exp_q.size()), 64'(0));

    // cyc_count wrap: 0xFFFE then three more enables
    mon_on = 1'b0;
    t = cyc;
    pulse(MODE_RUN);
    at(t + 65535);
    check("wrap_pre", 64'(cyc_count), 64'(16'hFFFE));
    at(t + 65537);
    step_pulse = 1'b1;
    at(t + 65538);
    step_pulse = 1'b0;
    check("wrap_post", 64'(cyc_count), 64'(16'h0001));
    check("wrap_en_off", 64'(cpu_en), 64'(0));
    check("wrap_state", 64'(state), 64'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
